// File: rtl/perf_event_counter.sv
// Performance-event counter bank: per-channel event counts plus run-cycle count, atomic snapshot, shadow read port.
// Latency: events reach the live counters 1 edge later; snapshot 1 edge; read data/ack 1 cycle after request.
// No backpressure: every read request is acked next cycle. Optional macro PERF_SATURATE_EN selects saturating counters.
module perf_event_counter #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 32,
   parameter int CYCLE_LIMIT = 30,
   localparam int SEL_W      = $clog2(NUM_CH + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [NUM_CH-1:0] event_i,
   input  logic              clr_i,
   input  logic              snap_i,
   input  logic              rd_req_i,
   input  logic [SEL_W-1:0]  rd_sel_i,
   output logic              rd_ack_o,
   output logic [CNT_W-1:0]  rd_data_o,
   output logic              rd_err_o,
   output logic [NUM_CH-1:0] ovf_o,
   output logic              done_o
);

   localparam logic [CNT_W-1:0] ONES      = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam bit               HAS_LIMIT = (CYCLE_LIMIT != 0);
   localparam logic [CNT_W-1:0] LIMIT_M1  = CNT_W'(CYCLE_LIMIT - 1);

   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_d [NUM_CH];
   logic [CNT_W-1:0]  cyc_q, cyc_d;
   logic [NUM_CH-1:0] ovf_q, ovf_d;
   logic              done_q, done_d;
   logic [CNT_W-1:0]  shd_q [NUM_CH+1];
   logic [CNT_W-1:0]  shd_d [NUM_CH+1];
   logic              rd_ack_q, rd_ack_d;
   logic [CNT_W-1:0]  rd_data_q, rd_data_d;
   logic              rd_err_q, rd_err_d;
   logic              active;

   // Live counter next state: clear beats counting; counting only while started and budget not reached.
   always_comb begin
      active = start_i & ~done_q;
      cnt_d  = cnt_q;
      cyc_d  = cyc_q;
      ovf_d  = ovf_q;
      done_d = done_q;
      if (clr_i) begin
         for (int k = 0; k < NUM_CH; k++) begin
            cnt_d[k] = '0;
         end
         cyc_d  = '0;
         ovf_d  = '0;
         done_d = 1'b0;
      end else if (active) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (event_i[k]) begin
               if (cnt_q[k] == ONES) begin
                  ovf_d[k] = 1'b1;
`ifdef PERF_SATURATE_EN
                  cnt_d[k] = ONES;
`else
                  cnt_d[k] = '0;
`endif
               end else begin
                  cnt_d[k] = cnt_q[k] + ONE;
               end
            end
         end
         if (cyc_q == ONES) begin
`ifdef PERF_SATURATE_EN
            cyc_d = ONES;
`else
            cyc_d = '0;
`endif
         end else begin
            cyc_d = cyc_q + ONE;
         end
         if (HAS_LIMIT && (cyc_q == LIMIT_M1)) begin
            done_d = 1'b1;
         end
      end
   end

   // Shadow capture takes the pre-edge live values, so same-cycle increments and clears are excluded.
   always_comb begin
      shd_d = shd_q;
      if (snap_i) begin
         for (int k = 0; k < NUM_CH; k++) begin
            shd_d[k] = cnt_q[k];
         end
         shd_d[NUM_CH] = cyc_q;
      end
   end

   // Read port: ack pulses one cycle per request; data and error hold until the next ack.
   always_comb begin
      rd_ack_d  = rd_req_i;
      rd_data_d = rd_data_q;
      rd_err_d  = rd_err_q;
      if (rd_req_i) begin
         if (int'(rd_sel_i) <= NUM_CH) begin
            rd_data_d = shd_q[rd_sel_i];
            rd_err_d  = 1'b0;
         end else begin
            rd_data_d = '0;
            rd_err_d  = 1'b1;
         end
      end
   end

   // State registers; reset clears everything including shadows and the read outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < NUM_CH; k++) begin
            cnt_q[k] <= '0;
         end
         for (int k = 0; k <= NUM_CH; k++) begin
            shd_q[k] <= '0;
         end
         cyc_q     <= '0;
         ovf_q     <= '0;
         done_q    <= 1'b0;
         rd_ack_q  <= 1'b0;
         rd_data_q <= '0;
         rd_err_q  <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         shd_q     <= shd_d;
         cyc_q     <= cyc_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
         rd_ack_q  <= rd_ack_d;
         rd_data_q <= rd_data_d;
         rd_err_q  <= rd_err_d;
      end
   end

   assign rd_ack_o  = rd_ack_q;
   assign rd_data_o = rd_data_q;
   assign rd_err_o  = rd_err_q;
   assign ovf_o     = ovf_q;
   assign done_o    = done_q;

endmodule

// File: tb/tb_perf_event_counter.sv
// Directed bench for perf_event_counter: budget run, gating, clear priority, read port, async reset, overflow.
// Default instance (CNT_W=32, CYCLE_LIMIT=30) plus an 8-bit unlimited instance for wrap/saturation.
// Expected values are hand-computed constants; PERF_SATURATE_EN selects the overflow expectations.
module tb_perf_event_counter;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       start_i, clr_i, snap_i, rd_req_i;
   logic [3:0] event_i;
   logic [2:0] rd_sel_i;
   logic       rd_ack_o, rd_err_o, done_o;
   logic [31:0] rd_data_o;
   logic [3:0] ovf_o;

   logic       start2, clr2, snap2, req2;
   logic [3:0] ev2;
   logic [2:0] sel2;
   logic       ack2, err2, done2;
   logic [7:0] data2;
   logic [3:0] ovf2;

   int checks   = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   perf_event_counter u_dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .event_i(event_i),
      .clr_i(clr_i), .snap_i(snap_i), .rd_req_i(rd_req_i), .rd_sel_i(rd_sel_i),
      .rd_ack_o(rd_ack_o), .rd_data_o(rd_data_o), .rd_err_o(rd_err_o),
      .ovf_o(ovf_o), .done_o(done_o)
   );

   perf_event_counter #(.NUM_CH(4), .CNT_W(8), .CYCLE_LIMIT(0)) u_ovf (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start2), .event_i(ev2),
      .clr_i(clr2), .snap_i(snap2), .rd_req_i(req2), .rd_sel_i(sel2),
      .rd_ack_o(ack2), .rd_data_o(data2), .rd_err_o(err2),
      .ovf_o(ovf2), .done_o(done2)
   );

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [2:0] sel, input logic [63:0] exp, input logic exp_err, input string tag);
      rd_req_i = 1'b1;
      rd_sel_i = sel;
      tick;
      chk({tag, "_ack"}, 64'(rd_ack_o), 64'd1);
      chk({tag, "_data"}, 64'(rd_data_o), exp);
      chk({tag, "_err"}, 64'(rd_err_o), 64'(exp_err));
      rd_req_i = 1'b0;
      tick;
      chk({tag, "_ack_drop"}, 64'(rd_ack_o), 64'd0);
      chk({tag, "_hold"}, 64'(rd_data_o), exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ovf_exp;
`ifdef PERF_SATURATE_EN
      ovf_exp = 8'd255;
`else
      ovf_exp = 8'd4;
`endif
      rst_i = 1'b1; start_i = 0; clr_i = 0; snap_i = 0; rd_req_i = 0; event_i = '0; rd_sel_i = '0;
      start2 = 0; clr2 = 0; snap2 = 0; req2 = 0; ev2 = '0; sel2 = '0;
      repeat (2) tick;
      chk("rst_ack", 64'(rd_ack_o), 64'd0);
      chk("rst_data", 64'(rd_data_o), 64'd0);
      chk("rst_err", 64'(rd_err_o), 64'd0);
      chk("rst_ovf", 64'(ovf_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      rst_i = 1'b0;
      tick;

      // Budget run: ch0 7 events, ch1 3 events, done after exactly 30 edges.
      start_i = 1'b1;
      for (int i = 0; i < 30; i++) begin
         event_i = {2'b00, (i >= 10 && i < 13), (i < 7)};
         tick;
         if (i == 28) chk("done_early", 64'(done_o), 64'd0);
      end
      chk("done_at_30", 64'(done_o), 64'd1);
      event_i = 4'hF;
      repeat (3) tick;
      chk("done_held", 64'(done_o), 64'd1);
      event_i = '0;
      snap_i = 1'b1; tick; snap_i = 1'b0;
      rd(3'd0, 64'd7, 1'b0, "bud_ch0");
      rd(3'd1, 64'd3, 1'b0, "bud_ch1");
      rd(3'd4, 64'd30, 1'b0, "bud_cyc");
      rd(3'd2, 64'd0, 1'b0, "bud_frozen_ch2");

      // Back-to-back reads including an out-of-range select.
      rd_req_i = 1'b1; rd_sel_i = 3'd0; tick;
      chk("b2b0_ack", 64'(rd_ack_o), 64'd1);
      chk("b2b0_data", 64'(rd_data_o), 64'd7);
      rd_sel_i = 3'd1; tick;
      chk("b2b1_ack", 64'(rd_ack_o), 64'd1);
      chk("b2b1_data", 64'(rd_data_o), 64'd3);
      rd_sel_i = 3'd5; tick;
      chk("b2b2_ack", 64'(rd_ack_o), 64'd1);
      chk("b2b2_data", 64'(rd_data_o), 64'd0);
      chk("b2b2_err", 64'(rd_err_o), 64'd1);
      rd_req_i = 1'b0; tick;
      chk("b2b_ack_drop", 64'(rd_ack_o), 64'd0);
      chk("b2b_err_hold", 64'(rd_err_o), 64'd1);

      // Gating: no counting while start_i is low.
      start_i = 1'b0;
      clr_i = 1'b1; tick; clr_i = 1'b0;
      chk("clr_done", 64'(done_o), 64'd0);
      for (int i = 0; i < 5; i++) begin
         event_i = (i % 2 == 1) ? 4'hF : 4'h5;
         tick;
      end
      event_i = '0;
      snap_i = 1'b1; tick; snap_i = 1'b0;
      rd(3'd0, 64'd0, 1'b0, "gate_ch0");
      rd(3'd2, 64'd0, 1'b0, "gate_ch2");
      rd(3'd4, 64'd0, 1'b0, "gate_cyc");

      // Clear priority with simultaneous snap, event and read.
      start_i = 1'b1; event_i = 4'h1;
      repeat (9) tick;
      clr_i = 1'b1; snap_i = 1'b1; rd_req_i = 1'b1; rd_sel_i = 3'd0;
      tick;
      chk("snaprd_old_shadow", 64'(rd_data_o), 64'd0);
      clr_i = 0; snap_i = 0; rd_req_i = 0; start_i = 0; event_i = '0;
      chk("clrp_ovf", 64'(ovf_o), 64'd0);
      rd(3'd0, 64'd9, 1'b0, "clrp_shadow_ch0");
      rd(3'd4, 64'd9, 1'b0, "clrp_shadow_cyc");
      snap_i = 1'b1; tick; snap_i = 1'b0;
      rd(3'd0, 64'd0, 1'b0, "clrp_after_ch0");
      rd(3'd4, 64'd0, 1'b0, "clrp_after_cyc");

      // Async reset mid-run, between edges.
      start_i = 1'b1; event_i = 4'h1;
      repeat (11) tick;
      snap_i = 1'b1; tick; snap_i = 1'b0;
      start_i = 1'b0; event_i = '0; rd_req_i = 1'b1; rd_sel_i = 3'd0;
      tick;
      rd_req_i = 1'b0;
      chk("pre_rst_data", 64'(rd_data_o), 64'd11);
      #2 rst_i = 1'b1;
      #1;
      chk("arst_ack", 64'(rd_ack_o), 64'd0);
      chk("arst_data", 64'(rd_data_o), 64'd0);
      chk("arst_done", 64'(done_o), 64'd0);
      chk("arst_ovf", 64'(ovf_o), 64'd0);
      #1 rst_i = 1'b0;
      tick;
      rd(3'd0, 64'd0, 1'b0, "arst_shadow");
      start_i = 1'b1; event_i = 4'h1;
      repeat (3) tick;
      start_i = 1'b0; event_i = '0;
      snap_i = 1'b1; tick; snap_i = 1'b0;
      rd(3'd0, 64'd3, 1'b0, "resume_ch0");
      rd(3'd4, 64'd3, 1'b0, "resume_cyc");

      // 8-bit overflow: 260 events on ch0 and 260 active cycles.
      start2 = 1'b1; ev2 = 4'h1;
      repeat (255) tick;
      chk("ovf_not_yet", 64'(ovf2), 64'd0);
      repeat (5) tick;
      chk("ovf_set", 64'(ovf2), 64'd1);
      start2 = 1'b0; ev2 = '0;
      snap2 = 1'b1; tick; snap2 = 1'b0;
      req2 = 1'b1; sel2 = 3'd0; tick;
      chk("ovf_rd_ack", 64'(ack2), 64'd1);
      chk("ovf_rd_ch0", 64'(data2), 64'(ovf_exp));
      sel2 = 3'd4; tick;
      chk("ovf_rd_cyc", 64'(data2), 64'(ovf_exp));
      req2 = 1'b0;
      chk("ovf_done_never", 64'(done2), 64'd0);
      clr2 = 1'b1; tick; clr2 = 1'b0;
      chk("ovf_cleared", 64'(ovf2), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
